// File: rtl/sram_pkg.sv
// Shared constants and FSM state encoding for the simple-dual-port SRAM model.
// Read-during-write selectors map directly onto the RDW_MODE parameter value.
package sram_pkg;

    localparam int RDW_OLD_DATA = 0;
    localparam int RDW_NEW_DATA = 1;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-result shift register, RD_LATENCY stages deep; one result per cycle, no backpressure.
// Data stages load only when a valid result enters them, so the output holds between reads.
module sram_rd_pipe #(
    parameter int WIDTH      = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_dat
);

    logic [RD_LATENCY-1:0] vld_q;
    logic [RD_LATENCY-1:0] vld_d;
    logic [WIDTH-1:0]      dat_q [RD_LATENCY];
    logic [WIDTH-1:0]      dat_d [RD_LATENCY];

    always_comb begin
        vld_d[0] = in_vld;
        dat_d[0] = in_vld ? in_dat : dat_q[0];
        for (int k = 1; k < RD_LATENCY; k++) begin
            vld_d[k] = vld_q[k-1];
            dat_d[k] = vld_q[k-1] ? dat_q[k-1] : dat_q[k];
        end
    end

    // Only the output stage data is cleared so rd_dout reads zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
        for (int k = 0; k < RD_LATENCY; k++) begin
            if (rst && (k == RD_LATENCY - 1)) begin
                dat_q[k] <= '0;
            end else begin
                dat_q[k] <= dat_d[k];
            end
        end
    end

    assign out_vld = vld_q[RD_LATENCY-1];
    assign out_dat = dat_q[RD_LATENCY-1];

endmodule

// File: rtl/sram_dp_sync.sv
// Simple-dual-port SRAM with byte enables and post-reset clear; read data valid RD_LATENCY
// cycles after the rd_en edge. No backpressure; requests are ignored until init_done.
module sram_dp_sync
    import sram_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter int               DEPTH      = 16,
    parameter int               RD_LATENCY = 1,
    parameter int               RDW_MODE   = 0,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0,
    localparam int              ADDR_WIDTH = $clog2(DEPTH),
    localparam int              BE_WIDTH   = WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_done,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [BE_WIDTH-1:0]   wr_be,
    input  logic [WIDTH-1:0]      wr_din,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic [WIDTH-1:0]      rd_dout
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

    if (WIDTH % 8 != 0) begin : g_bad_width
        $error("sram_dp_sync: WIDTH must be a multiple of 8");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("sram_dp_sync: RD_LATENCY must be in 1..4");
    end
    if (RDW_MODE > 1) begin : g_bad_rdw
        $error("sram_dp_sync: RDW_MODE must be 0 or 1");
    end

    logic [WIDTH-1:0]      mem_q [DEPTH];
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  cap_vld_q, cap_vld_d;
    logic [WIDTH-1:0]      cap_dat_q, cap_dat_d;

    logic                  ready;
    logic                  wr_in_range, rd_in_range;
    logic                  wr_fire, rd_fire, collide;
    logic [WIDTH-1:0]      wr_old, wr_merged, rd_word;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [WIDTH-1:0]      mem_wdat;

    assign ready     = (state_q == ST_READY);
    assign init_done = ready;

    always_comb begin
        wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
        rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
        wr_fire     = ready & wr_en & wr_in_range;
        rd_fire     = ready & rd_en;
        collide     = wr_fire & rd_in_range & (rd_addr == wr_addr);
        wr_old      = wr_in_range ? mem_q[wr_addr] : '0;
        wr_merged   = wr_old;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (wr_be[i]) begin
                wr_merged[8*i +: 8] = wr_din[8*i +: 8];
            end
        end
    end

    // Clear sequencer owns the write port until READY.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        mem_we     = 1'b0;
        mem_waddr  = wr_addr;
        mem_wdat   = wr_merged;
        if (state_q == ST_CLEAR) begin
            mem_we     = 1'b1;
            mem_waddr  = clr_addr_q;
            mem_wdat   = INIT_VALUE;
            clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
            if (clr_addr_q == LAST_ADDR) begin
                state_d    = ST_READY;
                clr_addr_d = '0;
            end
        end else if (wr_fire) begin
            mem_we = 1'b1;
        end
    end

    // The read word is captured at the rd_en edge, so later writes cannot disturb it.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            if ((RDW_MODE == RDW_NEW_DATA) && collide) begin
                rd_word = wr_merged;
            end else begin
                rd_word = mem_q[rd_addr];
            end
        end
        cap_vld_d = rd_fire;
        cap_dat_d = rd_fire ? rd_word : cap_dat_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            cap_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            cap_vld_q  <= cap_vld_d;
            cap_dat_q  <= cap_dat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[mem_waddr] <= mem_wdat;
        end
    end

    sram_rd_pipe #(
        .WIDTH      (WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (cap_vld_q),
        .in_dat  (cap_dat_q),
        .out_vld (rd_valid),
        .out_dat (rd_dout)
    );

endmodule

// File: tb/tb_sram_dp_sync.sv
// Three SRAM configurations driven by one stimulus stream, each checked against a
// word-array model with a queue of read results due on specific cycles.
module tb_sram_dp_sync;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        wr_en, rd_en;
    logic [3:0]  wr_addr, rd_addr, wr_be;
    logic [31:0] wr_din;

    logic        init_done_w [3];
    logic        rd_valid_w  [3];
    logic [31:0] rd_dout_w   [3];

    sram_dp_sync #(.WIDTH(32), .DEPTH(16), .RD_LATENCY(1), .RDW_MODE(0),
                   .INIT_VALUE(32'hC0DE_0001)) u_old (
        .clk(clk), .rst(rst), .init_done(init_done_w[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_din(wr_din),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid_w[0]), .rd_dout(rd_dout_w[0]));

    sram_dp_sync #(.WIDTH(32), .DEPTH(16), .RD_LATENCY(3), .RDW_MODE(1),
                   .INIT_VALUE(32'h0000_0000)) u_new (
        .clk(clk), .rst(rst), .init_done(init_done_w[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_din(wr_din),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid_w[1]), .rd_dout(rd_dout_w[1]));

    sram_dp_sync #(.WIDTH(32), .DEPTH(12), .RD_LATENCY(2), .RDW_MODE(0),
                   .INIT_VALUE(32'h1234_5678)) u_odd (
        .clk(clk), .rst(rst), .init_done(init_done_w[2]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_din(wr_din),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid_w[2]), .rd_dout(rd_dout_w[2]));

    typedef struct {
        int          d;
        int          due;
        logic [31:0] val;
    } ent_t;

    int          m_depth [3];
    int          m_lat   [3];
    bit          m_new   [3];
    logic [31:0] m_init  [3];
    logic [31:0] m_mem   [3][16];
    bit          m_ready [3];
    int          m_clr   [3];
    logic [31:0] m_last  [3];
    ent_t        pq[$];
    int          cyc;
    int          tests;
    int          fails;

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] din, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = din[8*b +: 8];
        end
        return r;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge();
        logic [31:0] v;
        cyc++;
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                m_ready[d] = 1'b0;
                m_clr[d]   = 0;
                m_last[d]  = 32'h0;
                for (int i = pq.size() - 1; i >= 0; i--) begin
                    if (pq[i].d == d) pq.delete(i);
                end
            end else if (!m_ready[d]) begin
                m_mem[d][m_clr[d]] = m_init[d];
                m_clr[d]++;
                if (m_clr[d] == m_depth[d]) m_ready[d] = 1'b1;
            end else begin
                if (rd_en) begin
                    if (int'(rd_addr) >= m_depth[d]) v = 32'h0;
                    else if (m_new[d] && wr_en && wr_addr == rd_addr)
                        v = merge(m_mem[d][rd_addr], wr_din, wr_be);
                    else v = m_mem[d][rd_addr];
                    pq.push_back('{d, cyc + m_lat[d], v});
                end
                if (wr_en && int'(wr_addr) < m_depth[d])
                    m_mem[d][wr_addr] = merge(m_mem[d][wr_addr], wr_din, wr_be);
            end
        end
    endtask

    task automatic check_all();
        bit          ev;
        logic [31:0] ed;
        for (int d = 0; d < 3; d++) begin
            ev = 1'b0;
            ed = m_last[d];
            for (int i = 0; i < pq.size(); i++) begin
                if (pq[i].d == d && pq[i].due == cyc) begin
                    ev = 1'b1;
                    ed = pq[i].val;
                    m_last[d] = ed;
                    pq.delete(i);
                    break;
                end
            end
            check($sformatf("init_done_u%0d", d), {31'b0, init_done_w[d]}, {31'b0, m_ready[d]});
            check($sformatf("rd_valid_u%0d", d), {31'b0, rd_valid_w[d]}, {31'b0, ev});
            check($sformatf("rd_dout_u%0d", d), rd_dout_w[d], ed);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(bit we, logic [3:0] wa, logic [3:0] be, logic [31:0] wd,
                         bit re, logic [3:0] ra);
        wr_en   = we;
        wr_addr = wa;
        wr_be   = be;
        wr_din  = wd;
        rd_en   = re;
        rd_addr = ra;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    endtask

    task automatic rand_drive();
        logic [3:0] wa;
        wa = 4'($urandom_range(0, 15));
        drive(1'($urandom_range(0, 1)), wa, 4'($urandom), $urandom,
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15)));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cyc   = 0;
        m_depth = '{16, 16, 12};
        m_lat   = '{1, 3, 2};
        m_new   = '{1'b0, 1'b1, 1'b0};
        m_init  = '{32'hC0DE_0001, 32'h0000_0000, 32'h1234_5678};
        rst = 1'b1;
        idle();
        tick();
        tick();

        // Clear sequence: init_done low for DEPTH cycles, then every address reads INIT_VALUE.
        rst = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        check("t1_init_low_u2_at_11", {31'b0, init_done_w[2]}, 32'h0);
        tick();
        check("t1_init_high_u2_at_12", {31'b0, init_done_w[2]}, 32'h1);
        for (int i = 0; i < 3; i++) tick();
        check("t1_init_low_u0_at_15", {31'b0, init_done_w[0]}, 32'h0);
        tick();
        check("t1_init_high_u0_at_16", {31'b0, init_done_w[0]}, 32'h1);
        for (int a = 0; a < 16; a++) begin
            drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(a));
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) tick();

        // Byte-enable merge.
        drive(1'b1, 4'd3, 4'hF, 32'hAABB_CCDD, 1'b0, 4'h0);
        tick();
        drive(1'b1, 4'd3, 4'b0101, 32'h1122_3344, 1'b0, 4'h0);
        tick();
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd3);
        tick();
        idle();
        tick();
        check("t2_merge_u0", rd_dout_w[0], 32'hAA22_CC44);
        for (int i = 0; i < 3; i++) tick();

        // Pipelined reads on the 3-cycle instance.
        for (int a = 0; a < 3; a++) begin
            drive(1'b1, 4'(a), 4'hF, 32'h100 + a, 1'b0, 4'h0);
            tick();
        end
        for (int a = 0; a < 3; a++) begin
            drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(a));
            tick();
        end
        idle();
        check("t3_not_yet_u1", {31'b0, rd_valid_w[1]}, 32'h0);
        for (int a = 0; a < 3; a++) begin
            tick();
            check("t3_valid_u1", {31'b0, rd_valid_w[1]}, 32'h1);
            check("t3_data_u1", rd_dout_w[1], 32'h100 + a);
        end
        tick();
        check("t3_drop_u1", {31'b0, rd_valid_w[1]}, 32'h0);
        check("t3_hold_u1", rd_dout_w[1], 32'h102);

        // Read-during-write, old vs new data.
        drive(1'b1, 4'd5, 4'hF, 32'h0, 1'b0, 4'h0);
        tick();
        drive(1'b1, 4'd5, 4'hF, 32'hFFFF_FFFF, 1'b1, 4'd5);
        tick();
        idle();
        tick();
        check("t4_old_u0", rd_dout_w[0], 32'h0);
        tick();
        check("t4_old_u2", rd_dout_w[2], 32'h0);
        tick();
        check("t4_new_u1", rd_dout_w[1], 32'hFFFF_FFFF);

        // Out-of-range address on the 12-deep instance.
        drive(1'b1, 4'd13, 4'hF, 32'hDEAD_BEEF, 1'b0, 4'h0);
        tick();
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd13);
        tick();
        idle();
        tick();
        check("t6_inrange_u0", rd_dout_w[0], 32'hDEAD_BEEF);
        tick();
        check("t6_oor_valid_u2", {31'b0, rd_valid_w[2]}, 32'h1);
        check("t6_oor_zero_u2", rd_dout_w[2], 32'h0);
        for (int a = 0; a < 16; a++) begin
            drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(a));
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) tick();

        // Random traffic with frequent same-address collisions.
        for (int i = 0; i < 400; i++) begin
            rand_drive();
            tick();
        end

        // Reset during the clear restarts it; requests during the clear are ignored.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rand_drive();
            wr_en = 1'b1;
            rd_en = 1'b1;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            rand_drive();
            wr_en = 1'b1;
            rd_en = 1'b1;
            tick();
        end
        check("t5_init_low_u1_at_15", {31'b0, init_done_w[1]}, 32'h0);
        check("t5_no_read_u1", {31'b0, rd_valid_w[1]}, 32'h0);
        idle();
        tick();
        check("t5_init_high_u1_at_16", {31'b0, init_done_w[1]}, 32'h1);
        for (int a = 0; a < 16; a++) begin
            drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(a));
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
